// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a single-outstanding fetch FSM feeding a DEPTH-entry {pc, word} FIFO.
// Optional macro IFQ_BYPASS_EN forwards a response straight to the core when the queue is empty.
module instr_fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      mem_read,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic [DATA_W-1:0]         instruction,
  output logic [ADDR_W-1:0]         instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] word_mem [DEPTH];

  logic req_fire;
  logic resp_fire;
  logic head_valid;
  logic bypass;
  logic push;
  logic pop;

  // Only IDLE issues, so the one in-flight slot is already reserved whenever count < DEPTH here.
  assign mem_read   = reset && (state_q == IDLE) && (count_q < FULL_CNT) && !redirect_valid;
  assign mem_addr   = reset ? fetch_pc_q : '0;
  assign req_fire   = mem_read && mem_ready;
  assign resp_fire  = (state_q == WAIT) && mem_rvalid;
  assign head_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = resp_fire && !head_valid && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_fire && !redirect_valid && !(bypass && instr_ready);
  assign pop  = head_valid && instr_ready && !redirect_valid;

  assign instr_valid = head_valid || bypass;
  assign instruction = head_valid ? word_mem[rd_ptr_q] : (bypass ? mem_rdata : '0);
  assign instr_pc    = head_valid ? pc_mem[rd_ptr_q]   : (bypass ? req_pc_q  : '0);
  assign count       = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          state_d    = WAIT;
        end
      end
      WAIT:    if (mem_rvalid) state_d = IDLE;
      DROP:    if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A redirect flushes everything; a request already in flight must have its reply discarded.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if (((state_q == IDLE) && req_fire) || ((state_q == WAIT) && !mem_rvalid))
        state_d = DROP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) req_pc_q <= fetch_pc_q;
    if (push) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      word_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by randomized traffic against a queue model.
module tb_instr_fetch_queue;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RPC    = 32'h0;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   mem_read;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_ready = 1'b0;
  logic                   mem_rvalid = 1'b0;
  logic [DATA_W-1:0]      mem_rdata = '0;
  logic                   redirect_valid = 1'b0;
  logic [ADDR_W-1:0]      redirect_pc = '0;
  logic [DATA_W-1:0]      instruction;
  logic [ADDR_W-1:0]      instr_pc;
  logic                   instr_valid;
  logic                   instr_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instruction(instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count)
  );

  int total = 0;
  int bad = 0;
  int n_req = 0;

  typedef struct packed {logic [31:0] pc; logic [31:0] w;} ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_live;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch = RPC;
    m_pc    = '0;
    m_pend  = 1'b0;
    m_live  = 1'b0;
  endtask

  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit rdr, input logic [31:0] rpc, input bit irdy);
    mem_ready      = rdy;
    mem_rvalid     = rv;
    mem_rdata      = rd;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    instr_ready    = irdy;
  endtask

  // Check outputs mid-cycle against the model, then advance the model across the next rising edge.
  task automatic cycle();
    bit   exp_read, exp_valid, byp, pop, resp;
    ent_t head;
    @(negedge clk);
    if (!reset) model_reset();
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = reset && (m_q.size() == 0) && m_pend && m_live && mem_rvalid && !redirect_valid;
`endif
    exp_read  = reset && !m_pend && (m_q.size() < DEPTH) && !redirect_valid;
    exp_valid = (m_q.size() > 0) || byp;
    if (m_q.size() > 0) head = m_q[0];
    else if (byp)       head = {m_pc, mem_rdata};
    else                head = '0;
    chk("mem_read", mem_read, exp_read);
    if (exp_read || !reset) chk("mem_addr", mem_addr, exp_read ? m_fetch : 32'h0);
    chk("instr_valid", instr_valid, exp_valid);
    if (exp_valid || !reset) begin
      chk("instr_pc", instr_pc, head.pc);
      chk("instruction", instruction, head.w);
    end
    chk("count", count, m_q.size());
    if (mem_read && mem_ready) n_req++;
    if (reset) begin
      pop  = (m_q.size() > 0) && instr_ready && !redirect_valid;
      resp = m_pend && mem_rvalid;
      if (redirect_valid) begin
        m_q.delete();
        m_fetch = redirect_pc;
        if (resp) m_pend = 1'b0;
        else if (m_pend) m_live = 1'b0;
      end else begin
        if (pop) m_q.delete(0);
        if (resp) begin
          if (m_live && !(byp && instr_ready)) m_q.push_back({m_pc, mem_rdata});
          m_pend = 1'b0;
        end
        if (exp_read && mem_ready) begin
          m_pend  = 1'b1;
          m_live  = 1'b1;
          m_pc    = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("rst_count", count, 0);

    // First fetch right after reset release, one-cycle response.
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("first_read", mem_read, 1);
    chk("first_addr", mem_addr, RPC);
    cycle();
    drive(1, 1, 32'h20010001, 0, 0, 0);
    #1;
    chk("wait_no_read", mem_read, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("addr4", mem_addr, 32'h4);
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 32'h0);
    chk("first_word", instruction, 32'h20010001);
    cycle();

    // Fill without consuming: exactly DEPTH requests.
    for (int i = 0; i < 12; i++) begin
      drive(1, m_pend, 32'hA0000000 + 32'(i), 0, 0, 0);
      cycle();
    end
    chk("fill_reqs", n_req, 4);
    chk("fill_count", count, 4);
    chk("fill_noread", mem_read, 0);
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, m_pend, 32'hB0000000 + 32'(i), 0, 0, 0);
      cycle();
    end
    chk("refill_reqs", n_req, 5);
    chk("refill_count", count, 4);
    chk("refill_head", instr_pc, 32'h4);

    // Simultaneous push and pop, then drain in order.
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("pp_addr", mem_addr, 32'h14);
    cycle();
    drive(0, 1, 32'hC0DE0014, 0, 0, 1);
    #1;
    chk("pp_count_pre", count, 3);
    cycle();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("pp_count_post", count, 3);
    chk("order_c", instr_pc, 32'hC);
    cycle();
    #1;
    chk("order_10", instr_pc, 32'h10);
    cycle();
    #1;
    chk("order_14", instr_pc, 32'h14);
    chk("order_14_word", instruction, 32'hC0DE0014);
    cycle();

    // Redirect while a request is in flight.
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("pre_redir_addr", mem_addr, 32'h18);
    cycle();
    drive(1, 0, 0, 1, 32'h100, 0);
    cycle();
    drive(1, 1, 32'hDEADBEEF, 0, 0, 0);
    #1;
    chk("drop_noread", mem_read, 0);
    chk("drop_count", count, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("redir_read", mem_read, 1);
    chk("redir_addr", mem_addr, 32'h100);
    chk("redir_count", count, 0);
    cycle();
    drive(1, 1, 32'h13, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("redir_valid", instr_valid, 1);
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_word", instruction, 32'h13);
    cycle();

    // Address wrap.
    drive(0, 0, 0, 1, 32'hFFFFFFFC, 1);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_top", mem_addr, 32'hFFFFFFFC);
    cycle();
    drive(1, 1, 32'h77, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_addr0", mem_addr, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFFFFFC);
    cycle();

    // Reset while waiting; the late response must be ignored.
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_read", mem_read, 0);
    chk("midrst_count", count, 0);
    chk("midrst_valid", instr_valid, 0);
    cycle();
    reset = 1'b1;
    drive(0, 1, 32'hBAD0BAD0, 0, 0, 0);
    #1;
    chk("postrst_read", mem_read, 1);
    chk("postrst_addr", mem_addr, RPC);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("postrst_count", count, 0);
    chk("postrst_valid", instr_valid, 0);
    cycle();

    // Randomized traffic with occasional redirects, stray responses and resets.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0,
            m_pend ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0),
            $urandom,
            $urandom_range(0, 15) == 0,
            $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
